// File: rtl/lcd_watch_pkg.sv
//------------------------------------------------------------------------------
// Module  : lcd_watch_pkg
// Brief   : Shared types, ASCII constants and byte-count helper for the LCD path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcd_watch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } lcd_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // Command byte plus one byte per digit plus one colon per full digit pair.
  function automatic int n_bytes(input int num_digits, input int colon_en);
    return 1 + num_digits + ((colon_en != 0) ? (num_digits - 1) / 2 : 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bcd_to_ascii.sv
//------------------------------------------------------------------------------
// Module  : lcd_bcd_to_ascii
// Brief   : Combinational BCD digit to ASCII; non-decimal codes blank to a space.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_bcd_to_ascii
  import lcd_watch_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_ascii
);

  assign o_ascii = (i_bcd <= 4'd9) ? (ASCII_ZERO + {4'h0, i_bcd}) : ASCII_SPACE;

endmodule

`default_nettype wire

// File: rtl/lcd_digit_writer.sv
//------------------------------------------------------------------------------
// Module  : lcd_digit_writer
// Brief   : Snapshots packed BCD digits and writes them as one LCD line with timed E strobes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_digit_writer
  import lcd_watch_pkg::*;
#(
  parameter int         NUM_DIGITS    = 6,
  parameter int         COLON_EN      = 1,
  parameter logic [7:0] LINE_ADDR     = 8'h80,
  parameter int         SETUP_CYCLES  = 2,
  parameter int         ENABLE_CYCLES = 4,
  parameter int         HOLD_CYCLES   = 2
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic [4*NUM_DIGITS-1:0] BCD_IN,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    LCD_E,
  output logic                    LCD_RS,
  output logic                    LCD_RW,
  output logic [7:0]              LCD_DATA
);

  localparam int N_BYTES   = n_bytes(NUM_DIGITS, COLON_EN);
  localparam int MAX_SE    = (SETUP_CYCLES > ENABLE_CYCLES) ? SETUP_CYCLES : ENABLE_CYCLES;
  localparam int MAX_PHASE = (MAX_SE > HOLD_CYCLES) ? MAX_SE : HOLD_CYCLES;
  localparam int TMR_W     = $clog2(MAX_PHASE + 1);
  localparam int IDX_W     = $clog2(N_BYTES + 1);

  lcd_state_t              r_state, w_next;
  logic [TMR_W-1:0]        r_tmr, w_phase_last;
  logic [IDX_W-1:0]        r_idx, w_load_idx;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [7:0]              r_data, w_sel_byte;
  logic                    r_rs, w_sel_rs;
  logic                    w_phase_end, w_accept, w_last_byte;
  logic [7:0]              w_ascii [NUM_DIGITS];

  // Character position p = j-1 after the command byte; every third position is a colon.
  function automatic bit is_colon(input int j);
    return (COLON_EN != 0) && (((j - 1) % 3) == 2);
  endfunction

  function automatic int digit_slot(input int j);
    int p;
    p = j - 1;
    return NUM_DIGITS - 1 - ((COLON_EN != 0) ? (p - p / 3) : p);
  endfunction

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_conv
    lcd_bcd_to_ascii u_conv (
      .i_bcd   (r_snap[4*g +: 4]),
      .o_ascii (w_ascii[g])
    );
  end

  always_comb begin
    case (r_state)
      ST_SETUP: w_phase_last = TMR_W'(SETUP_CYCLES - 1);
      ST_PULSE: w_phase_last = TMR_W'(ENABLE_CYCLES - 1);
      default:  w_phase_last = TMR_W'(HOLD_CYCLES - 1);
    endcase
  end

  assign w_phase_end = (r_tmr == w_phase_last);
  assign w_accept    = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_byte = (r_idx == IDX_W'(N_BYTES - 1));
  assign w_load_idx  = r_idx + IDX_W'(1);

  always_comb begin
    w_next = r_state;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    LCD_E  = 1'b0;
    case (r_state)
      ST_IDLE: w_next = START ? ST_SETUP : ST_IDLE;
      ST_DONE: begin
        DONE   = 1'b1;
        w_next = START ? ST_SETUP : ST_IDLE;
      end
      ST_SETUP: begin
        BUSY = 1'b1;
        if (w_phase_end) w_next = ST_PULSE;
      end
      ST_PULSE: begin
        BUSY  = 1'b1;
        LCD_E = 1'b1;
        if (w_phase_end) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        BUSY = 1'b1;
        if (w_phase_end) w_next = w_last_byte ? ST_DONE : ST_SETUP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_byte = LINE_ADDR;
    w_sel_rs   = 1'b0;
    for (int j = 1; j < N_BYTES; j++) begin
      if (w_load_idx == IDX_W'(j)) begin
        w_sel_rs = 1'b1;
        if (is_colon(j)) w_sel_byte = ASCII_COLON;
        else             w_sel_byte = w_ascii[digit_slot(j)];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_tmr  <= '0;
      r_idx  <= '0;
      r_snap <= '0;
      r_data <= 8'h00;
      r_rs   <= 1'b0;
    end else begin
      if ((w_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_DONE))
        r_tmr <= '0;
      else
        r_tmr <= r_tmr + TMR_W'(1);

      // The bus is only reloaded on SETUP entry, so it parks on the last byte after DONE.
      if (w_accept) begin
        r_snap <= BCD_IN;
        r_idx  <= '0;
        r_data <= LINE_ADDR;
        r_rs   <= 1'b0;
      end else if ((r_state == ST_HOLD) && w_phase_end) begin
        r_idx <= w_load_idx;
        if (!w_last_byte) begin
          r_data <= w_sel_byte;
          r_rs   <= w_sel_rs;
        end
      end
    end
  end

  assign LCD_DATA = r_data;
  assign LCD_RS   = r_rs;
  assign LCD_RW   = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_lcd_digit_writer.sv
//------------------------------------------------------------------------------
// Module  : tb_lcd_digit_writer
// Brief   : Self-checking bench: per-cycle behavioural model plus literal sequence checks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lcd_digit_writer;

  localparam int ND = 6;
  localparam int S  = 2;
  localparam int E  = 4;
  localparam int H  = 2;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic [4*ND-1:0] BCD_IN = '0;
  logic          START = 1'b0;
  logic          BUSY, DONE, LCD_E, LCD_RS, LCD_RW;
  logic [7:0]    LCD_DATA;

  logic [3:0]    BCD_B = '0;
  logic          START_B = 1'b0;
  logic          BUSY_B, DONE_B, LCD_E_B, LCD_RS_B, LCD_RW_B;
  logic [7:0]    LCD_DATA_B;

  lcd_digit_writer #(
    .NUM_DIGITS(ND), .COLON_EN(1), .LINE_ADDR(8'h80),
    .SETUP_CYCLES(S), .ENABLE_CYCLES(E), .HOLD_CYCLES(H)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .BCD_IN(BCD_IN), .START(START),
    .BUSY(BUSY), .DONE(DONE), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  lcd_digit_writer #(
    .NUM_DIGITS(1), .COLON_EN(0), .LINE_ADDR(8'h80),
    .SETUP_CYCLES(1), .ENABLE_CYCLES(1), .HOLD_CYCLES(1)
  ) dut_b (
    .CLK(CLK), .RESETN(RESETN), .BCD_IN(BCD_B), .START(START_B),
    .BUSY(BUSY_B), .DONE(DONE_B), .LCD_E(LCD_E_B), .LCD_RS(LCD_RS_B),
    .LCD_RW(LCD_RW_B), .LCD_DATA(LCD_DATA_B)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- behavioural model of DUT A ----------------
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       e;
    logic       rs;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;

  function automatic logic [7:0] to_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h20;
  endfunction

  // Expand the byte string of one write into its cycle-by-cycle output trace.
  task automatic build_trace(input logic [4*ND-1:0] snap);
    logic [8:0] bytes[$];
    bytes.push_back({1'b0, 8'h80});
    for (int d = ND - 1; d >= 0; d--) begin
      bytes.push_back({1'b1, to_char(snap[4*d +: 4])});
      if (d != 0 && ((ND - 1 - d) % 2) == 1) bytes.push_back({1'b1, 8'h3A});
    end
    foreach (bytes[i]) begin
      for (int c = 0; c < S; c++) q.push_back('{1'b1, 1'b0, 1'b0, bytes[i][8], bytes[i][7:0]});
      for (int c = 0; c < E; c++) q.push_back('{1'b1, 1'b0, 1'b1, bytes[i][8], bytes[i][7:0]});
      for (int c = 0; c < H; c++) q.push_back('{1'b1, 1'b0, 1'b0, bytes[i][8], bytes[i][7:0]});
    end
    q.push_back('{1'b0, 1'b1, 1'b0, bytes[$][8], bytes[$][7:0]});
  endtask

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      q.delete();
      cur = '0;
    end else begin
      if (START && !cur.busy) begin
        q.delete();
        build_trace(BCD_IN);
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{1'b0, 1'b0, 1'b0, cur.rs, cur.data};
    end
  end

  // ---------------- per-cycle compare and strobe capture ----------------
  logic [8:0] cap_a[$];
  logic [8:0] cap_b[$];
  logic       prev_e   = 1'b0;
  logic       prev_e_b = 1'b0;

  always @(negedge CLK) begin
    chk("cycle_outputs", {20'h0, BUSY, DONE, LCD_E, LCD_RS, LCD_DATA},
        {20'h0, cur.busy, cur.done, cur.e, cur.rs, cur.data});
    chk("lcd_rw", {31'h0, LCD_RW}, 32'h0);
    if (LCD_E && !prev_e) cap_a.push_back({LCD_RS, LCD_DATA});
    if (LCD_E_B && !prev_e_b) cap_b.push_back({LCD_RS_B, LCD_DATA_B});
    prev_e   = LCD_E;
    prev_e_b = LCD_E_B;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_a(output int scyc);
    START = 1'b1;
    scyc  = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic start_b(output int scyc);
    START_B = 1'b1;
    scyc    = cyc;
    tick();
    START_B = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit on_b, output int dcyc);
    bit seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if ((on_b ? DONE_B : DONE) === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    if (!seen) chk({name, "_done_timeout"}, 32'h0, 32'h1);
  endtask

  logic [8:0] exp_seq[$];

  task automatic check_seq(input string name, input bit on_b);
    int n;
    n = on_b ? cap_b.size() : cap_a.size();
    chk({name, "_count"}, n, exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < n; i++)
      chk({name, "_byte"}, on_b ? cap_b[i] : cap_a[i], exp_seq[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, d;

    repeat (3) tick();
    chk("reset_busy", BUSY, 0);
    chk("reset_e", LCD_E, 0);
    chk("reset_data", LCD_DATA, 8'h00);
    chk("reset_b_outputs", {BUSY_B, DONE_B, LCD_E_B, LCD_RS_B, LCD_RW_B, LCD_DATA_B}, 0);

    RESETN = 1'b1;
    repeat (20) tick();
    chk("idle_no_strobe", cap_a.size(), 0);
    chk("idle_busy", BUSY, 0);

    // Basic write: bytes and DONE latency (START sampled in cycle s, DONE in s+73).
    BCD_IN = 24'h123059;
    cap_a.delete();
    start_a(s);
    wait_done("w123059", 1'b0, d);
    chk("w123059_latency", d - s, 73);
    exp_seq = '{9'h080, 9'h131, 9'h132, 9'h13A, 9'h133, 9'h130, 9'h13A, 9'h135, 9'h139};
    check_seq("w123059", 1'b0);
    repeat (3) tick();

    // Blanking plus a mid-write input change that must not reach the bus.
    BCD_IN = 24'hF9A001;
    cap_a.delete();
    start_a(s);
    repeat (10) tick();
    BCD_IN = 24'h777777;
    wait_done("wF9A001", 1'b0, d);
    exp_seq = '{9'h080, 9'h120, 9'h139, 9'h13A, 9'h120, 9'h130, 9'h13A, 9'h130, 9'h131};
    check_seq("wF9A001", 1'b0);
    repeat (2) tick();

    // START re-pulsed while busy is ignored.
    BCD_IN = 24'h235959;
    cap_a.delete();
    start_a(s);
    repeat (12) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (20) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done("repulse", 1'b0, d);
    chk("repulse_latency", d - s, 73);
    chk("repulse_strobes", cap_a.size(), 9);
    repeat (3) tick();

    // START held through DONE: back-to-back write with no idle gap.
    BCD_IN = 24'h000000;
    cap_a.delete();
    START = 1'b1;
    tick();
    wait_done("held1", 1'b0, d);
    tick();
    chk("held_busy_after_done", BUSY, 1);
    START = 1'b0;
    wait_done("held2", 1'b0, d);
    chk("held_strobes", cap_a.size(), 18);
    repeat (3) tick();

    // Reset during the 4th byte's strobe aborts; the next write restarts from LINE_ADDR.
    BCD_IN = 24'h123059;
    cap_a.delete();
    start_a(s);
    for (int i = 0; i < 200 && !(cap_a.size() == 4 && LCD_E); i++) tick();
    chk("abort_in_pulse", {cap_a.size(), LCD_E}, {32'd4, 1'b1});
    #2;
    RESETN = 1'b0;
    #1;
    chk("abort_e_low", LCD_E, 0);
    chk("abort_busy_low", BUSY, 0);
    chk("abort_data_zero", LCD_DATA, 8'h00);
    repeat (2) tick();
    RESETN = 1'b1;
    repeat (2) tick();
    cap_a.delete();
    start_a(s);
    wait_done("restart", 1'b0, d);
    exp_seq = '{9'h080, 9'h131, 9'h132, 9'h13A, 9'h133, 9'h130, 9'h13A, 9'h135, 9'h139};
    check_seq("restart", 1'b0);

    // Random traffic: model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      BCD_IN = 24'($urandom);
      START  = ($urandom_range(0, 7) == 0);
      tick();
    end
    START = 1'b0;
    repeat (90) tick();
    chk("random_idle_at_end", BUSY, 0);

    // Minimal configuration: one digit, no colons, 1/1/1 timing.
    BCD_B = 4'h7;
    cap_b.delete();
    start_b(s);
    wait_done("small7", 1'b1, d);
    chk("small7_latency", d - s, 7);
    exp_seq = '{9'h080, 9'h137};
    check_seq("small7", 1'b1);
    tick();
    BCD_B = 4'hC;
    cap_b.delete();
    start_b(s);
    wait_done("smallC", 1'b1, d);
    exp_seq = '{9'h080, 9'h120};
    check_seq("smallC", 1'b1);
    tick();
    chk("small_idle_after_done", {BUSY_B, DONE_B, LCD_E_B}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
